t01_wishbone_manager: RTL

Converts single-word requests from the CPU request unit into classic Wishbone B4 single read/write cycles on the shared bus. Accepts a one-cycle request pulse, returns `busy_o` and the read data to the request unit, and aborts a stalled cycle after a bounded number of bus cycles. It sits directly downstream of `t01_request_unit` and upstream of the Wishbone interconnect and RAM.

---
 rtl/t01_wb_pkg.sv | 15 +
 rtl/t01_wb_timeout.sv | 31 +++
 rtl/t01_wishbone_manager.sv | 122 ++++++++++++
 3 files changed

// File: rtl/t01_wb_pkg.sv
// Shared Wishbone manager types: FSM states, default abort data, request bundle.
package t01_wb_pkg;

  typedef enum logic [1:0] {IDLE, LATCH, BUS} wb_state_t;

  localparam logic [31:0] WB_ERR_DATA = 32'hBAD0_BAD0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

endpackage

// File: rtl/t01_wb_timeout.sv
// Clearable saturating bus-cycle counter; expired is a compare on the registered count,
// so it flags the cycle in which the count has reached TIMEOUT_CYCLES-1. No backpressure.
module t01_wb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Holds at LAST rather than wrapping.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/t01_wishbone_manager.sv
// Single-word request pulse -> Wishbone B4 classic cycle; 3 cycles pulse-to-completion minimum.
// Pulses arriving while busy are dropped; a slave stalling TIMEOUT_CYCLES strobes is aborted.
module t01_wishbone_manager
  import t01_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = WB_ERR_DATA
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] cpu_dat_i,
  input  logic [3:0]  sel_i,
  output logic        busy_o,
  output logic [31:0] cpu_dat_o,
  output logic        bus_err_o,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        CYC_O,
  output logic        STB_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  wb_state_t   state, state_n;
  wb_req_t     req_q, req_n;
  logic        op_we, op_we_n;
  logic        busy_n, cyc_n, err_n;
  logic [31:0] rdat_n;
  logic        tmo_clr, tmo_en, tmo_expired;

  t01_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .nRST   (nRST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  assign ADR_O = req_q.adr;
  assign DAT_O = req_q.dat;
  assign SEL_O = req_q.sel;
  assign WE_O  = req_q.we;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      req_q     <= '0;
      op_we     <= 1'b0;
      busy_o    <= 1'b0;
      cpu_dat_o <= '0;
      bus_err_o <= 1'b0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
    end else begin
      state     <= state_n;
      req_q     <= req_n;
      op_we     <= op_we_n;
      busy_o    <= busy_n;
      cpu_dat_o <= rdat_n;
      bus_err_o <= err_n;
      CYC_O     <= cyc_n;
      STB_O     <= cyc_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req_q;
    op_we_n = op_we;
    busy_n  = busy_o;
    cyc_n   = CYC_O;
    rdat_n  = cpu_dat_o;
    err_n   = bus_err_o;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    unique case (state)
      IDLE: begin
        // A simultaneous read+write is treated as a read.
        if (read_i || write_i) begin
          state_n = LATCH;
          busy_n  = 1'b1;
          op_we_n = write_i & ~read_i;
        end
      end
      LATCH: begin
        // Address sampled one cycle late: instruction fetches present it after the pulse.
        req_n.adr = adr_i;
        req_n.dat = cpu_dat_i;
        req_n.sel = sel_i;
        req_n.we  = op_we;
        cyc_n     = 1'b1;
        tmo_clr   = 1'b1;
        state_n   = BUS;
      end
      BUS: begin
        if (ACK_I || tmo_expired) begin
          cyc_n   = 1'b0;
          busy_n  = 1'b0;
          req_n   = '0;
          state_n = IDLE;
          if (ACK_I) begin
            if (!req_q.we) rdat_n = DAT_I;
          end else begin
            err_n = 1'b1;
            if (!req_q.we) rdat_n = ERR_DATA;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
